// File: rtl/tawas_dmem_arb_pkg.sv
// Shared constants and helpers for the tawas data-memory arbiter.
//   NSEC_DEF         default number of secondary requesters
//   ADDR_W_DEF       default SRAM word-address width
//   STARVE_LIMIT_DEF default wait count at which a port reports starvation
//   clog2()          width helper, never returns less than 1 so a 1-entry
//                    pointer still gets a real bit
package tawas_dmem_arb_pkg;

  localparam int NSEC_DEF         = 2;
  localparam int ADDR_W_DEF       = 14;
  localparam int STARVE_LIMIT_DEF = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tawas_dmem_arb_if.sv
// Bus bundle around the data-memory arbiter.
//   core_*  : tawas core data port (no stall, always wins)
//   sec_*   : NSEC secondary requesters, req/gnt handshake, packed per port
//   ram_*   : single-port SRAM, 1-cycle read latency
// slave  : the arbiter's view
// master : the requesters' and SRAM model's view
interface tawas_dmem_arb_if
  import tawas_dmem_arb_pkg::*;
#(
  parameter int NSEC   = NSEC_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic                 core_cs;
  logic                 core_wr;
  logic [31:0]          core_addr;
  logic [3:0]           core_mask;
  logic [31:0]          core_wdata;
  logic [31:0]          core_rdata;

  logic [NSEC-1:0]      sec_req;
  logic [NSEC-1:0]      sec_gnt;
  logic [NSEC-1:0]      sec_wr;
  logic [NSEC*32-1:0]   sec_addr;
  logic [NSEC*4-1:0]    sec_mask;
  logic [NSEC*32-1:0]   sec_wdata;
  logic [NSEC-1:0]      sec_rvld;
  logic [31:0]          sec_rdata;
  logic [NSEC-1:0]      sec_starved;

  logic                 ram_cs;
  logic                 ram_wr;
  logic [ADDR_W-1:0]    ram_addr;
  logic [3:0]           ram_mask;
  logic [31:0]          ram_wdata;
  logic [31:0]          ram_rdata;

  modport slave (
    input  core_cs, core_wr, core_addr, core_mask, core_wdata,
    output core_rdata,
    input  sec_req, sec_wr, sec_addr, sec_mask, sec_wdata,
    output sec_gnt, sec_rvld, sec_rdata, sec_starved,
    output ram_cs, ram_wr, ram_addr, ram_mask, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output core_cs, core_wr, core_addr, core_mask, core_wdata,
    input  core_rdata,
    output sec_req, sec_wr, sec_addr, sec_mask, sec_wdata,
    input  sec_gnt, sec_rvld, sec_rdata, sec_starved,
    input  ram_cs, ram_wr, ram_addr, ram_mask, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/tawas_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : last winner; search starts at (ptr+1) mod N
//   enable  : when low no grant is produced
//   gnt     : one-hot grant
//   gnt_idx : index of the granted port (0 when none)
module tawas_rr_pick
  import tawas_dmem_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int PTR_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  logic found;
  int   p;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    p       = 0;
    for (int k = 1; k <= N; k++) begin
      p = (int'(ptr) + k) % N;
      if (enable && !found && req[p]) begin
        found   = 1'b1;
        gnt[p]  = 1'b1;
        gnt_idx = PTR_W'(p);
      end
    end
  end

endmodule

// File: rtl/tawas_dmem_arb.sv
// Data-SRAM arbiter: tawas core data port has absolute priority, secondary
// requesters share the idle cycles round-robin.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : core / secondary / SRAM signal bundle (slave modport)
// Read data is a pass-through of ram_rdata; sec_rvld tags which secondary
// owns it, one cycle after that port's read grant.
module tawas_dmem_arb
  import tawas_dmem_arb_pkg::*;
#(
  parameter int NSEC         = NSEC_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  tawas_dmem_arb_if.slave bus
);

  localparam int PTR_W = clog2(NSEC);
  localparam int CNT_W = clog2(STARVE_LIMIT + 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [NSEC-1:0]  gnt;
  logic [NSEC-1:0]  rvld;
  logic [CNT_W-1:0] wait_cnt [NSEC];
  logic [NSEC-1:0]  starved;
  logic             pick_en;
  logic             core_go;
  logic [31:0]      sel_addr;
  logic             unused_addr;

  // Holding rst low forces both the core path and the picker off.
  assign core_go = rst & bus.core_cs;
  assign pick_en = rst & ~bus.core_cs;

  tawas_rr_pick #(.N(NSEC)) u_pick (
    .req     (bus.sec_req),
    .ptr     (rr_ptr),
    .enable  (pick_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel_addr = bus.sec_addr[32*int'(gnt_idx) +: 32];

  always_comb begin
    bus.ram_cs    = 1'b0;
    bus.ram_wr    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_mask  = '0;
    bus.ram_wdata = '0;
    if (core_go) begin
      bus.ram_cs    = 1'b1;
      bus.ram_wr    = bus.core_wr;
      bus.ram_addr  = bus.core_addr[ADDR_W+1:2];
      bus.ram_mask  = bus.core_mask;
      bus.ram_wdata = bus.core_wdata;
    end else if (|gnt) begin
      bus.ram_cs    = 1'b1;
      bus.ram_wr    = bus.sec_wr[gnt_idx];
      bus.ram_addr  = sel_addr[ADDR_W+1:2];
      bus.ram_mask  = bus.sec_mask[4*int'(gnt_idx) +: 4];
      bus.ram_wdata = bus.sec_wdata[32*int'(gnt_idx) +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= PTR_W'(NSEC - 1);
      rvld   <= '0;
    end else begin
      if (|gnt) rr_ptr <= gnt_idx;
      rvld <= gnt & ~bus.sec_wr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSEC; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NSEC; i++) begin
        if (bus.sec_req[i] && !gnt[i]) begin
          if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    starved = '0;
    for (int i = 0; i < NSEC; i++) starved[i] = (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
  end

  assign bus.sec_gnt     = gnt;
  assign bus.sec_rvld    = rvld;
  assign bus.sec_starved = starved;
  assign bus.core_rdata  = bus.ram_rdata;
  assign bus.sec_rdata   = bus.ram_rdata;

  // Address bits outside the word index are intentionally ignored.
  assign unused_addr = ^{bus.core_addr[31:ADDR_W+2], bus.core_addr[1:0],
                         sel_addr[31:ADDR_W+2], sel_addr[1:0]};

endmodule

// File: doc/tawas_dmem_arb.md
Name: tawas_dmem_arb

Overview:
- Shares one single-port, 1-cycle-latency data SRAM between the tawas core data port and NSEC secondary requesters (DMA, debug loader).
- The core data port has no stall input, so it always has absolute priority.
- Secondary requesters take the remaining idle cycles by round-robin, using a req/gnt handshake.
- Read responses are tagged back to the winning secondary one cycle after its grant.

Parameters:
NSEC, 2, number of secondary requesters (1..8)
ADDR_W, 14, SRAM word-address width; byte address bits [ADDR_W+1:2] are used
STARVE_LIMIT, 64, wait cycles before a secondary's starvation flag asserts (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
core_cs  in  1  core data access strobe
core_wr  in  1  core write (1) / read (0)
core_addr  in  32  core byte address
core_mask  in  4  core byte-write enables
core_wdata  in  32  core write data
core_rdata  out  32  core read data, valid the cycle after core_cs
sec_req  in  NSEC  secondary request; payload held stable until gnt
sec_gnt  out  NSEC  one-hot grant; the access occurs in the same cycle
sec_wr  in  NSEC  per-port write flag
sec_addr  in  NSEC*32  per-port byte address, port i at [32i+31:32i]
sec_mask  in  NSEC*4  per-port byte enables
sec_wdata  in  NSEC*32  per-port write data
sec_rvld  out  NSEC  read-data valid, one-hot, registered
sec_rdata  out  32  shared read data, qualified by sec_rvld
sec_starved  out  NSEC  wait counter at STARVE_LIMIT
ram_cs  out  1  SRAM chip select
ram_wr  out  1  SRAM write
ram_addr  out  ADDR_W  SRAM word address
ram_mask  out  4  SRAM byte enables
ram_wdata  out  32  SRAM write data
ram_rdata  in  32  SRAM read data, 1 cycle after ram_cs

Behaviour:
- Reset (rst low) is asynchronous:
  - rr_ptr = NSEC-1, so port 0 is searched first.
  - sec_rvld = 0; all wait counters = 0; sec_starved = 0.
  - While rst is low, sec_gnt = 0 and ram_cs = 0, regardless of the other inputs.
- Arbitration is combinational within a cycle:
  - If core_cs = 1: ram_* are driven from core_*, and sec_gnt = 0.
  - Else, if any sec_req bit is set: the first requesting port at or after (rr_ptr+1) mod NSEC wins. Its gnt is asserted and ram_* are driven from its payload.
  - Else: ram_cs = 0; the other ram_* outputs are don't-care but driven stably to 0.
- rr_ptr updates on a secondary grant only; a core cycle or an idle cycle leaves it unchanged.
- Address handling: ram_addr = addr[ADDR_W+1:2]. Upper bits and bits [1:0] are ignored; there is no range error.
- Read return:
  - core_rdata = ram_rdata, passed through directly.
  - sec_rdata = ram_rdata.
  - sec_rvld[i] is registered: it is 1 in cycle t+1 iff port i was granted a read in cycle t.
  - Writes never produce sec_rvld.
- Back-to-back grants to the same port with no other requester: allowed every cycle, and rvld pipelines at one per cycle.
- Wait counter per port:
  - Increments when req=1 and gnt=0, saturating at STARVE_LIMIT.
  - Clears to 0 on a grant, or when req=0.
  - sec_starved[i] = (counter == STARVE_LIMIT). It is status only; core priority is never overridden.
- If a requester drops req before gnt, nothing is recorded for it. A mid-transfer reset discards any pending sec_rvld.

Decomposition:
- Package tawas_dmem_arb_pkg holds:
  - default constants NSEC_DEF=2, ADDR_W_DEF=14, STARVE_LIMIT_DEF=64;
  - a function clog2, used to size rr_ptr and the wait counters.
- One sub-module, tawas_rr_pick (parameter N), is natural:
  - inputs: req[N], ptr[clog2 N], enable;
  - outputs: one-hot gnt[N], gnt_idx;
  - purely combinational.
- The top holds the registers: rr_ptr, rvld pipeline, wait counters.

Test Plan:
- Core read at 0x0000_0010 with secondaries idle -> ram_addr=4, ram_cs=1, no sec_gnt; core_rdata = the SRAM word at 4 in the next cycle.
- sec_req=2'b11 held for 4 idle cycles, both reads -> grants in order 01,10,01,10; sec_rvld follows one cycle later each time; rr_ptr alternates.
- Core writes 0xDEADBEEF with mask 4'b0011 while sec_req[0]=1 -> sec_gnt=0 that cycle, and ram_wdata/ram_mask come from the core. Port 0 is granted in the first cycle core_cs=0; a read of the same word returns 0x????BEEF.
- core_cs held high for 70 cycles with sec_req[1]=1 -> sec_starved[1] rises after 64 cycles and stays high. It clears the cycle after the grant that follows core_cs dropping.
- Port 1 read granted in cycle t, and rst asserted low in cycle t+1 before the clock edge -> sec_rvld=0 immediately and after reset release; rr_ptr=NSEC-1.
- Single port 0 issues 8 back-to-back reads -> 8 consecutive grants, and 8 consecutive sec_rvld pulses offset by one cycle.
